fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader_pkg.sv | 12 +
 rtl/fifo_reader_if.sv | 38 +++
 rtl/fifo_reader_buf.sv | 57 +++++
 rtl/fifo_reader.sv | 58 +++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared memory-side constants for the synchronous FIFO and its reader.
package fifo_reader_pkg;

  // Default word width of the attached synchronous FIFO.
  localparam int MEM_DW = 32;

  // Words the reader is responsible for: buffered plus the one in flight.
  function automatic logic [2:0] occ_of(input logic [1:0] level, input logic inflight);
    return {1'b0, level} + {2'b0, inflight};
  endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// Bundle of the FIFO read port and the downstream valid/ready stream.
//
// Handshake semantics:
//   FIFO side: fifo_rd_en pops one word at the clk edge; that word is
//   presented on fifo_rd_data in the following cycle. fifo_rd_en is never
//   raised while fifo_empty is high.
//   Stream side: a word moves at every clk edge where out_valid && out_ready.
//   While out_valid is high and the word has not moved, out_data is held
//   stable; out_valid does not depend on out_ready.
interface fifo_reader_if
  import fifo_reader_pkg::*;
#(
  parameter int DW = MEM_DW
) ();

  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
  logic [1:0]    level;
  logic          dbg_inflight;

  // Reader side.
  modport master (
    input  fifo_empty, fifo_rd_data, out_ready, flush,
    output fifo_rd_en, out_valid, out_data, level, dbg_inflight
  );

  // Environment side: FIFO plus downstream consumer.
  modport slave (
    output fifo_empty, fifo_rd_data, out_ready, flush,
    input  fifo_rd_en, out_valid, out_data, level, dbg_inflight
  );

endinterface

// File: rtl/fifo_reader_buf.sv
// Two-entry register queue (head, tail). A pop is applied before a push in
// the same cycle, so a push always lands in the first free entry after the pop.
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          clear,
  output logic [1:0]    level,
  output logic [DW-1:0] head_data
);

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    level_q, level_d;
  logic [1:0]    kept;

  // Next-state: pop first (tail shifts to head), then push into the free slot.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    kept    = level_q;
    if (pop && level_q != 2'd0) begin
      kept = level_q - 2'd1;
      if (level_q == 2'd2) head_d = tail_q;
    end
    level_d = kept;
    if (push) begin
      if (kept == 2'd0) head_d = push_data;
      else              tail_d = push_data;
      level_d = kept + 2'd1;
    end
    if (clear) level_d = 2'd0;
  end

  // State registers; reset also zeroes the data so out_data reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  assign level     = level_q;
  assign head_data = head_q;

endmodule

// File: rtl/fifo_reader.sv
// Converts a 1-cycle-latency rd_en/empty FIFO read port into a valid/ready
// stream. Reads are issued only when the word can be guaranteed a slot:
// either fewer than two words are owned (buffered + in flight) or a word
// leaves this cycle.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  fifo_reader_if.master bus
);

  logic          inflight_q, inflight_d;
  logic          pop;
  logic          push;
  logic          rd_en;
  logic [1:0]    level;
  logic [2:0]    occ;
  logic [DW-1:0] head_data;

  assign pop   = (level != 2'd0) && bus.out_ready;
  assign occ   = occ_of(level, inflight_q);
  // out_ready reaches rd_en only through pop: a leaving word frees a slot.
  assign rd_en = !bus.fifo_empty && !bus.flush && !rst && ((occ < 3'd2) || pop);
  // A word in flight during flush is dropped; during reset the buffer resets.
  assign push  = inflight_q && !bus.flush;

  // The word requested this cycle arrives next cycle.
  always_comb begin
    inflight_d = rd_en;
  end

  // In-flight flag register.
  always_ff @(posedge clk) begin
    if (rst) inflight_q <= 1'b0;
    else     inflight_q <= inflight_d;
  end

  fifo_reader_buf #(.DW(DW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.fifo_rd_data),
    .pop       (pop),
    .clear     (bus.flush),
    .level     (level),
    .head_data (head_data)
  );

  assign bus.fifo_rd_en   = rd_en;
  assign bus.out_valid    = (level != 2'd0);
  assign bus.out_data     = head_data;
  assign bus.level        = level;
  assign bus.dbg_inflight = inflight_q;

endmodule
